// File: rtl/present_round_ctrl.sv
// ============================================================================
// Module  : present_round_ctrl
// Brief   : Round sequencer for the masked PRESENT-128 datapath (control only).
// Revision: 1.0
// ============================================================================
`default_nettype none

module present_round_ctrl #(
    parameter int NROUNDS  = 31,
    parameter int PDSBOX   = 0,
    parameter int SBOX_LAT = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 ld_state,
    output logic                                 sb_en,
    output logic [((PDSBOX > 0) ? PDSBOX : 1)-1:0] sb_sel,
    output logic                                 rnd_req,
    output logic                                 upd_en,
    output logic [4:0]                           round_ctr,
    output logic                                 fin_en,
    output logic                                 valid_out
);

    localparam int SW     = (PDSBOX > 0) ? PDSBOX : 1;
    localparam int SB_DIV = 1 << PDSBOX;
    localparam int CMAX   = (SB_DIV > SBOX_LAT) ? SB_DIV : SBOX_LAT;
    localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] ISSUE_LAST = CW'(SB_DIV - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(SBOX_LAT - 1);
    localparam logic [4:0]    NR5        = 5'(NROUNDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ISSUE  = 3'd2,
        S_DRAIN  = 3'd3,
        S_UPDATE = 3'd4,
        S_FINAL  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    round_q, round_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
        end
    end

    // One counter serves both the slice index in ISSUE and the drain wait.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        round_d   = round_q;
        ld_state  = 1'b0;
        sb_en     = 1'b0;
        sb_sel    = '0;
        rnd_req   = 1'b0;
        upd_en    = 1'b0;
        fin_en    = 1'b0;
        valid_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                ld_state = 1'b1;
                round_d  = 5'd1;
                cnt_d    = '0;
                state_d  = S_ISSUE;
            end
            S_ISSUE: begin
                sb_en   = 1'b1;
                rnd_req = 1'b1;
                sb_sel  = SW'(cnt_q);
                if (cnt_q == ISSUE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_UPDATE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_UPDATE: begin
                upd_en = 1'b1;
                // Counter saturates at NROUNDS so FINAL/DONE still see the last round.
                if (round_q < NR5) begin
                    round_d = round_q + 5'd1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                fin_en  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                valid_out = 1'b1;
                round_d   = '0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign round_ctr = round_q;

endmodule

`default_nettype wire

// File: tb/tb_present_round_ctrl.sv
// ============================================================================
// Module  : tb_present_round_ctrl
// Brief   : Directed bench for present_round_ctrl, default and wide-slice builds.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_present_round_ctrl;

    localparam int NR = 31;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst     = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;

    logic       a_busy, a_ld, a_sben, a_rnd, a_upd, a_fin, a_val;
    logic [0:0] a_sel;
    logic [4:0] a_rc;
    logic       b_busy, b_ld, b_sben, b_rnd, b_upd, b_fin, b_val;
    logic [1:0] b_sel;
    logic [4:0] b_rc;

    present_round_ctrl #(.NROUNDS(31), .PDSBOX(0), .SBOX_LAT(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(a_busy), .ld_state(a_ld),
        .sb_en(a_sben), .sb_sel(a_sel), .rnd_req(a_rnd), .upd_en(a_upd),
        .round_ctr(a_rc), .fin_en(a_fin), .valid_out(a_val)
    );

    present_round_ctrl #(.NROUNDS(31), .PDSBOX(2), .SBOX_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(b_busy), .ld_state(b_ld),
        .sb_en(b_sben), .sb_sel(b_sel), .rnd_req(b_rnd), .upd_en(b_upd),
        .round_ctr(b_rc), .fin_en(b_fin), .valid_out(b_val)
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    int sbd[2] = '{1, 4};
    int slat[2] = '{2, 3};
    int latency[2] = '{126, 250};

    int mk[2]      = '{0, 0};
    int sedge[2]   = '{0, 0};
    int vedge[2]   = '{0, 0};
    int ld_n[2], rnd_n[2], upd_n[2], fin_n[2], val_n[2], selsum[2], rc5_n[2], rc31_n[2], rc0mid_n[2];

    logic [13:0] obs[2];

    // Output vector: {busy, ld, sb_en, sel[1:0], rnd, upd, rc[4:0], fin, valid}
    function automatic logic [13:0] exp_out(int k, int d, int sl, int lat);
        int p, j, off;
        logic [13:0] o;
        o = '0;
        if (k == 0) return o;
        o[13] = 1'b1;
        p = d + sl + 1;
        if (k == 1) begin
            o[12] = 1'b1;
        end else if (k <= 1 + NR * p) begin
            j = k - 2;
            off = j % p;
            o[6:2] = 5'(j / p + 1);
            if (off < d) begin
                o[11] = 1'b1;
                o[10:9] = 2'(off);
                o[8] = 1'b1;
            end else if (off == p - 1) begin
                o[7] = 1'b1;
            end
        end else begin
            o[6:2] = 5'(NR);
            if (k == lat) o[1] = 1'b1;
            else o[0] = 1'b1;
        end
        return o;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, cyc);
    endtask

    // Advance one cycle: update the model from inputs seen at the edge, compare, count.
    task automatic step();
        logic st;
        logic [13:0] e;
        @(negedge clk);
        cyc++;
        obs[0] = {a_busy, a_ld, a_sben, 1'b0, a_sel, a_rnd, a_upd, a_rc, a_fin, a_val};
        obs[1] = {b_busy, b_ld, b_sben, b_sel, b_rnd, b_upd, b_rc, b_fin, b_val};
        for (int i = 0; i < 2; i++) begin
            st = (i == 0) ? start_a : start_b;
            if (rst) mk[i] = 0;
            else if (mk[i] == 0) mk[i] = st ? 1 : 0;
            else if (mk[i] == latency[i] + 1) mk[i] = 0;
            else mk[i] = mk[i] + 1;
            if (mk[i] == 1) begin
                sedge[i] = cyc;
                ld_n[i] = 0; rnd_n[i] = 0; upd_n[i] = 0; fin_n[i] = 0; val_n[i] = 0;
                selsum[i] = 0; rc5_n[i] = 0; rc31_n[i] = 0; rc0mid_n[i] = 0;
            end
            e = exp_out(mk[i], sbd[i], slat[i], latency[i]);
            n_total++;
            if (obs[i] == e) n_pass++;
            else $display("FAIL outputs_%0d: got %h expected %h (edge %0d, k %0d)", i, obs[i], e, cyc, mk[i]);
            ld_n[i]   += int'(obs[i][12]);
            rnd_n[i]  += int'(obs[i][8]);
            upd_n[i]  += int'(obs[i][7]);
            fin_n[i]  += int'(obs[i][1]);
            val_n[i]  += int'(obs[i][0]);
            if (obs[i][11]) selsum[i] += int'(obs[i][10:9]);
            if (obs[i][6:2] == 5'd5) rc5_n[i]++;
            if (obs[i][6:2] == 5'd31) rc31_n[i]++;
            if (obs[i][13] && !obs[i][12] && obs[i][6:2] == 5'd0) rc0mid_n[i]++;
            if (obs[i][0]) vedge[i] = cyc;
        end
        #1;
    endtask

    task automatic wait_valid(input int i, input int bound, output int edge_o);
        bit ok;
        ok = 1'b0;
        edge_o = -1;
        for (int n = 0; n < bound && !ok; n++) begin
            step();
            if (obs[i][0]) begin
                ok = 1'b1;
                edge_o = cyc;
            end
        end
        chk("valid_seen", int'(ok), 1);
    endtask

    task automatic wait_round(input int i, input int r, input bit drain, input int bound);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < bound && !ok; n++) begin
            step();
            if (obs[i][6:2] == 5'(r) && obs[i][13] &&
                (!drain || (!obs[i][11] && !obs[i][7]))) ok = 1'b1;
        end
        chk("round_reached", int'(ok), 1);
    endtask

    task automatic pulse_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    int ve1, ve2, ve;

    initial begin
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_busy", int'(a_busy), 0);
        chk("rst_rc", int'(a_rc), 0);
        chk("rst_valid", int'(a_val), 0);

        // Default build: single run
        pulse_a();
        chk("load_first", int'(a_ld), 1);
        chk("load_rc", int'(a_rc), 0);
        wait_valid(0, 300, ve);
        chk("latency_a", ve - sedge[0], 126);
        step();
        chk("upd_cnt", upd_n[0], 31);
        chk("rnd_cnt", rnd_n[0], 31);
        chk("fin_cnt", fin_n[0], 1);
        chk("val_cnt", val_n[0], 1);
        chk("ld_cnt", ld_n[0], 1);
        chk("rc5_cycles", rc5_n[0], 4);
        chk("rc31_cycles", rc31_n[0], 6);
        chk("rc0_midrun", rc0mid_n[0], 0);

        // Four-slice build, SBOX_LAT=3
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        wait_valid(1, 400, ve);
        chk("latency_b", ve - sedge[1], 250);
        chk("rnd_cnt_b", rnd_n[1], 124);
        chk("selsum_b", selsum[1], 186);
        chk("upd_cnt_b", upd_n[1], 31);
        step();

        // start raised in round 10 and held through DONE
        pulse_a();
        wait_round(0, 10, 1'b0, 100);
        start_a = 1'b1;
        wait_valid(0, 300, ve1);
        chk("latency_held", ve1 - sedge[0], 126);
        step();
        chk("idle_after_done", int'(a_busy), 0);
        step();
        chk("restart_load", int'(a_ld), 1);
        start_a = 1'b0;
        wait_valid(0, 300, ve2);
        chk("b2b_period", ve2 - ve1, 128);

        // Reset during round 15 drain aborts the run
        step();
        pulse_a();
        wait_round(0, 15, 1'b1, 200);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", int'(a_busy), 0);
        chk("abort_rc", int'(a_rc), 0);
        repeat (5) step();
        chk("abort_no_valid", val_n[0], 0);
        pulse_a();
        wait_valid(0, 300, ve);
        chk("latency_after_abort", ve - sedge[0], 126);
        step();

        // rst has priority over start in IDLE
        rst = 1'b1;
        start_a = 1'b1;
        step();
        chk("rst_prio_busy", int'(a_busy), 0);
        rst = 1'b0;
        step();
        chk("start_after_rst", int'(a_ld), 1);
        start_a = 1'b0;
        wait_valid(0, 300, ve);
        chk("latency_final", ve - sedge[0], 126);
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
